// File: rtl/rgmii_idelay_ctrl_pkg.sv
// Shared types for the RGMII IDELAYE2 tap controller: tap width, op codes and FSM states.
package rgmii_idelay_pkg;

    localparam int TAP_W  = 5;
    localparam int LANE_W = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_WAIT_RDY    = 3'd0,
        ST_INIT_LD     = 3'd1,
        ST_INIT_SETTLE = 3'd2,
        ST_IDLE        = 3'd3,
        ST_APPLY       = 3'd4,
        ST_SETTLE      = 3'd5,
        ST_VERIFY      = 3'd6,
        ST_RESP        = 3'd7
    } state_e;

    // A step that would wrap the 5-bit tap counter is refused rather than issued.
    function automatic logic tap_saturates(op_e op, logic [TAP_W-1:0] tap);
        return (op == OP_INC && tap == '1) || (op == OP_DEC && tap == '0);
    endfunction

endpackage

// File: rtl/rgmii_idelay_ctrl_if.sv
// Command/response bus of the IDELAY tap controller; master issues commands, slave answers.
interface rgmii_idelay_ctrl_if;

    logic                                  cmd_valid;
    logic                                  cmd_ready;
    logic [rgmii_idelay_pkg::LANE_W-1:0]   cmd_lane;
    logic [1:0]                            cmd_op;
    logic [rgmii_idelay_pkg::TAP_W-1:0]    cmd_tap;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [rgmii_idelay_pkg::TAP_W-1:0]    rsp_tap;
    logic                                  rsp_err;

    modport master (
        output cmd_valid, cmd_lane, cmd_op, cmd_tap, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tap, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_lane, cmd_op, cmd_tap, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tap, rsp_err
    );

endinterface

// File: rtl/rgmii_idelay_ctrl.sv
// Sequences IDELAYE2 VAR_LOAD lanes: init load from per-lane shadows, then load/inc/dec/read
// commands with a settle wait and CNTVALUEOUT readback check.
//   state       | meaning
//   WAIT_RDY    | waiting for IDELAYCTRL RDY
//   INIT_LD     | ld pulse for the current init lane
//   INIT_SETTLE | settle wait before the next init lane
//   IDLE        | accepting commands
//   APPLY       | ld/ce pulse of the accepted command
//   SETTLE      | settle wait; together with VERIFY spans SETTLE_CYCLES
//   VERIFY      | sample CNTVALUEOUT and compare with the shadow
//   RESP        | hold response until rsp_ready
module rgmii_idelay_ctrl
    import rgmii_idelay_pkg::*;
#(
    parameter int LANES         = 5,
    parameter int DEFAULT_TAP   = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     idelayctrl_rdy,
    rgmii_idelay_ctrl_if.slave       bus,
    output logic [LANES-1:0]         idelay_ld,
    output logic [LANES-1:0]         idelay_ce,
    output logic                     idelay_inc,
    output logic [TAP_W-1:0]         idelay_cntvaluein,
    input  logic [LANES*TAP_W-1:0]   idelay_cntvalueout,
    output logic                     busy
);

    localparam logic [LANE_W:0]      LANES_X   = (LANE_W+1)'(LANES);
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [TAP_W-1:0]     DEF_TAP   = TAP_W'(DEFAULT_TAP);
    localparam logic [LANES-1:0]     ONE_HOT0  = LANES'(1);

    state_e                  r_state;
    logic [LANE_W-1:0]       r_lane;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat;
    logic                    r_rdy_lost;
    logic [LANES*TAP_W-1:0]  r_shadow;
    logic [LANES-1:0]        r_ld;
    logic [LANES-1:0]        r_ce;
    logic                    r_inc;
    logic [TAP_W-1:0]        r_cv;
    logic                    r_busy;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [TAP_W-1:0]        r_rsp_tap;
    logic                    r_rsp_err;

    op_e                     w_op;
    logic                    w_accept;
    logic                    w_lane_ok;
    logic                    w_sat;
    logic [LANE_W-1:0]       w_next_lane;
    logic [TAP_W-1:0]        w_cmd_shadow;
    logic [TAP_W-1:0]        w_cur_shadow;
    logic [TAP_W-1:0]        w_next_shadow;
    logic [TAP_W-1:0]        w_readback;

    assign w_op          = op_e'(bus.cmd_op);
    assign w_accept      = bus.cmd_valid & r_cmd_ready;
    assign w_lane_ok     = {1'b0, bus.cmd_lane} < LANES_X;
    assign w_cmd_shadow  = r_shadow[bus.cmd_lane*TAP_W +: TAP_W];
    assign w_sat         = tap_saturates(w_op, w_cmd_shadow);
    assign w_next_lane   = r_lane + LANE_W'(1);
    assign w_cur_shadow  = r_shadow[r_lane*TAP_W +: TAP_W];
    assign w_next_shadow = r_shadow[w_next_lane*TAP_W +: TAP_W];
    assign w_readback    = idelay_cntvalueout[r_lane*TAP_W +: TAP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_RDY;
            r_lane      <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_rdy_lost  <= 1'b0;
            r_shadow    <= {LANES{DEF_TAP}};
            r_ld        <= '0;
            r_ce        <= '0;
            r_inc       <= 1'b0;
            r_cv        <= '0;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_tap   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_RDY: begin
                    if (idelayctrl_rdy) begin
                        r_lane  <= '0;
                        r_ld    <= ONE_HOT0;
                        r_cv    <= r_shadow[TAP_W-1:0];
                        r_state <= ST_INIT_LD;
                    end
                end
                ST_INIT_LD: begin
                    r_ld <= '0;
                    if (!idelayctrl_rdy) begin
                        r_state <= ST_WAIT_RDY;
                    end else begin
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_state <= ST_INIT_SETTLE;
                    end
                end
                ST_INIT_SETTLE: begin
                    if (!idelayctrl_rdy) begin
                        r_state <= ST_WAIT_RDY;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_lane == LAST_LANE) begin
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_lane  <= w_next_lane;
                        r_ld    <= ONE_HOT0 << w_next_lane;
                        r_cv    <= w_next_shadow;
                        r_state <= ST_INIT_LD;
                    end
                end
                ST_IDLE: begin
                    // A command already offered wins over a simultaneous RDY drop.
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_lane      <= bus.cmd_lane;
                        r_rdy_lost  <= !idelayctrl_rdy;
                        r_sat       <= 1'b0;
                        if (!w_lane_ok) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_tap   <= '0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            case (w_op)
                                OP_LOAD: begin
                                    r_ld <= ONE_HOT0 << bus.cmd_lane;
                                    r_cv <= bus.cmd_tap;
                                    r_shadow[bus.cmd_lane*TAP_W +: TAP_W] <= bus.cmd_tap;
                                    r_state <= ST_APPLY;
                                end
                                OP_INC, OP_DEC: begin
                                    if (w_sat) begin
                                        r_sat <= 1'b1;
                                    end else begin
                                        r_ce  <= ONE_HOT0 << bus.cmd_lane;
                                        r_inc <= (w_op == OP_INC);
                                        r_shadow[bus.cmd_lane*TAP_W +: TAP_W] <=
                                            (w_op == OP_INC) ? w_cmd_shadow + TAP_W'(1)
                                                             : w_cmd_shadow - TAP_W'(1);
                                    end
                                    r_state <= ST_APPLY;
                                end
                                default: r_state <= ST_VERIFY;
                            endcase
                        end
                    end else if (!idelayctrl_rdy) begin
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_WAIT_RDY;
                    end
                end
                ST_APPLY: begin
                    r_ld       <= '0;
                    r_ce       <= '0;
                    r_inc      <= 1'b0;
                    r_rdy_lost <= r_rdy_lost | !idelayctrl_rdy;
                    if (SETTLE_CYCLES > 1) begin
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 2);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state <= ST_VERIFY;
                    end
                end
                ST_SETTLE: begin
                    r_rdy_lost <= r_rdy_lost | !idelayctrl_rdy;
                    if (r_cnt == '0) r_state <= ST_VERIFY;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_VERIFY: begin
                    r_rdy_lost  <= r_rdy_lost | !idelayctrl_rdy;
                    r_rsp_tap   <= w_readback;
                    r_rsp_err   <= r_sat | (w_readback != w_cur_shadow);
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rdy_lost || !idelayctrl_rdy) begin
                            r_busy  <= 1'b1;
                            r_state <= ST_WAIT_RDY;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_rdy_lost <= r_rdy_lost | !idelayctrl_rdy;
                    end
                end
                default: r_state <= ST_WAIT_RDY;
            endcase
        end
    end

    assign idelay_ld         = r_ld;
    assign idelay_ce         = r_ce;
    assign idelay_inc        = r_inc;
    assign idelay_cntvaluein = r_cv;
    assign busy              = r_busy;
    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_tap       = r_rsp_tap;
    assign bus.rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_rgmii_idelay_ctrl.sv
// Randomized bench for rgmii_idelay_ctrl: an IDELAYE2 tap emulator plus a cycle-schedule
// model of expected strobes and responses, checked every cycle.
module tb_rgmii_idelay_ctrl;

    localparam int LANES = 5;
    localparam int DEF   = 7;
    localparam int S     = 4;
    localparam int INF   = 2147483647;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdy = 1'b0;
    logic [LANES-1:0]     ld, ce;
    logic                 inc, busy;
    logic [4:0]           cv;
    logic [LANES*5-1:0]   cvo;

    rgmii_idelay_ctrl_if bus();

    rgmii_idelay_ctrl #(.LANES(LANES), .DEFAULT_TAP(DEF), .SETTLE_CYCLES(S)) dut (
        .clk               (clk),
        .rst               (rst),
        .idelayctrl_rdy    (rdy),
        .bus               (bus),
        .idelay_ld         (ld),
        .idelay_ce         (ce),
        .idelay_inc        (inc),
        .idelay_cntvaluein (cv),
        .idelay_cntvalueout(cvo),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // IDELAYE2 emulation: the tap counter the DUT is steering.
    logic [4:0]       emu [LANES];
    logic [LANES-1:0] ovr = '0;
    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ld[i])      emu[i] <= cv;
            else if (ce[i]) emu[i] <= inc ? emu[i] + 5'd1 : emu[i] - 5'd1;
        end
    end
    always_comb begin
        cvo = '0;
        for (int i = 0; i < LANES; i++) cvo[i*5 +: 5] = ovr[i] ? 5'd5 : emu[i];
    end

    // Model: expected strobes per cycle and interval bounds for busy/cmd_ready/response.
    int   mshadow [LANES];
    int   ld_at [int];
    int   ce_at [int];
    int   cv_at [int];
    bit   inc_at [int];
    int   busy_fall = INF, busy_rise = INF;
    int   acc = -1, hs_end = -1;
    int   rsp_start = INF, rsp_end = INF;
    int   exp_tap = 0;
    bit   exp_err = 1'b0;
    bit   track = 1'b0;
    int   errors = 0, checks = 0;

    logic [31:0] h_ld [int], h_ce [int], h_inc [int], h_cv [int], h_busy [int];
    logic [31:0] h_rdy [int], h_rv [int], h_tap [int], h_err [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int   e_ld, e_ce;
        logic e_busy, e_rv, e_rdy;
        if (track) begin
            h_ld[cyc] = ld;  h_ce[cyc] = ce;  h_inc[cyc] = inc;  h_cv[cyc] = cv;
            h_busy[cyc] = busy;  h_rdy[cyc] = bus.cmd_ready;  h_rv[cyc] = bus.rsp_valid;
            h_tap[cyc] = bus.rsp_tap;  h_err[cyc] = bus.rsp_err;
            e_ld = ld_at.exists(cyc) ? ld_at[cyc] : 0;
            e_ce = ce_at.exists(cyc) ? ce_at[cyc] : 0;
            chk("ld", ld, e_ld);
            chk("ce", ce, e_ce);
            if (e_ld != 0) chk("cntvaluein", cv, cv_at[cyc]);
            if (e_ce != 0) chk("inc", inc, inc_at[cyc]);
            e_busy = (cyc < busy_fall) || (cyc >= busy_rise);
            e_rdy  = !e_busy && !(cyc > acc && cyc <= hs_end);
            e_rv   = (cyc >= rsp_start) && (cyc <= rsp_end);
            chk("busy", busy, e_busy);
            chk("cmd_ready", bus.cmd_ready, e_rdy);
            chk("rsp_valid", bus.rsp_valid, e_rv);
            if (e_rv) begin
                chk("rsp_tap", bus.rsp_tap, exp_tap);
                chk("rsp_err", bus.rsp_err, exp_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_rdy();
        rdy = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            ld_at[cyc + 1 + i*(1+S)] = 1 << i;
            cv_at[cyc + 1 + i*(1+S)] = mshadow[i];
        end
        busy_fall = cyc + LANES*(1+S) + 1;
        busy_rise = INF;
    endtask

    task automatic wait_idle();
        while (cyc < busy_fall || cyc <= hs_end) step();
    endtask

    task automatic start_cmd(input int lane, input int op, input int tap);
        bit sat = 1'b0;
        wait_idle();
        acc = cyc;
        bus.cmd_valid = 1'b1;
        bus.cmd_lane  = 3'(lane);
        bus.cmd_op    = 2'(op);
        bus.cmd_tap   = 5'(tap);
        hs_end  = INF;
        rsp_end = INF;
        if (lane >= LANES) begin
            rsp_start = acc + 1;
            exp_tap   = 0;
            exp_err   = 1'b1;
        end else begin
            case (op)
                0: begin
                    ld_at[acc+1] = 1 << lane;
                    cv_at[acc+1] = tap;
                    mshadow[lane] = tap;
                end
                1: if (mshadow[lane] == 31) sat = 1'b1;
                   else begin ce_at[acc+1] = 1 << lane; inc_at[acc+1] = 1'b1; mshadow[lane]++; end
                2: if (mshadow[lane] == 0) sat = 1'b1;
                   else begin ce_at[acc+1] = 1 << lane; inc_at[acc+1] = 1'b0; mshadow[lane]--; end
                default: ;
            endcase
            rsp_start = acc + ((op == 3) ? 2 : 2 + S);
            exp_tap   = ovr[lane] ? 5 : mshadow[lane];
            exp_err   = sat || (exp_tap != mshadow[lane]);
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int rdelay);
        while (cyc < rsp_start + rdelay) step();
        rsp_end = cyc;
        hs_end  = cyc;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic cmd(input int lane, input int op, input int tap, input int rdelay);
        start_cmd(lane, op, tap);
        finish_cmd(rdelay);
    endtask

    task automatic do_reset();
        int r = cyc;
        rst = 1'b1;
        rdy = 1'b0;
        for (int k = r + 1; k <= r + LANES*(1+S) + 2; k++) begin
            ld_at.delete(k);
            ce_at.delete(k);
        end
        busy_rise = r + 1;
        if (rsp_end > r)   rsp_end = r;
        if (rsp_start > r) rsp_start = INF;
        if (hs_end > r)    hs_end = r;
        for (int i = 0; i < LANES; i++) mshadow[i] = DEF;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int a, d, rc, r;
        bus.cmd_valid = 1'b0;
        bus.cmd_lane  = '0;
        bus.cmd_op    = '0;
        bus.cmd_tap   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < LANES; i++) mshadow[i] = DEF;

        step();
        step();
        track = 1'b1;
        step();
        rst = 1'b0;
        while (cyc < 10) step();
        raise_rdy();
        while (cyc < 37) step();
        chk("reset_busy", h_busy[2], 1);
        chk("reset_cmd_ready", h_rdy[2], 0);
        chk("reset_rsp_valid", h_rv[2], 0);
        chk("reset_rsp_tap", h_tap[2], 0);
        chk("init_ld0", h_ld[11], 5'b00001);
        chk("init_cv0", h_cv[11], 7);
        chk("init_gap", h_ld[12], 0);
        chk("init_ld1", h_ld[16], 5'b00010);
        chk("init_ld4", h_ld[31], 5'b10000);
        chk("init_cv4", h_cv[31], 7);
        chk("init_busy_last", h_busy[35], 1);
        chk("init_busy_done", h_busy[36], 0);

        cmd(2, 0, 19, 0);
        a = acc;
        chk("load2_ld", h_ld[a+1], 5'b00100);
        chk("load2_cv", h_cv[a+1], 19);
        chk("load2_early", h_rv[a+5], 0);
        chk("load2_rv", h_rv[a+6], 1);
        chk("load2_tap", h_tap[a+6], 19);
        chk("load2_err", h_err[a+6], 0);

        cmd(0, 0, 31, 1);
        cmd(0, 1, 0, 0);
        a = acc;
        chk("incsat_ce", h_ce[a+1], 0);
        chk("incsat_err", h_err[a+6], 1);
        chk("incsat_tap", h_tap[a+6], 31);
        cmd(0, 2, 0, 0);
        a = acc;
        chk("dec_ce", h_ce[a+1], 5'b00001);
        chk("dec_inc", h_inc[a+1], 0);
        chk("dec_tap", h_tap[a+6], 30);
        chk("dec_err", h_err[a+6], 0);

        cmd(6, 0, 3, 0);
        a = acc;
        chk("badlane_ld", h_ld[a+1], 0);
        chk("badlane_rv", h_rv[a+1], 1);
        chk("badlane_err", h_err[a+1], 1);
        chk("badlane_tap", h_tap[a+1], 0);

        ovr[3] = 1'b1;
        cmd(3, 0, 9, 0);
        a = acc;
        chk("mismatch_tap", h_tap[a+6], 5);
        chk("mismatch_err", h_err[a+6], 1);
        ovr[3] = 1'b0;

        cmd(1, 3, 0, 20);
        a = acc;
        chk("stall_rv", h_rv[a+21], 1);
        chk("stall_ready", h_rdy[a+21], 0);
        chk("stall_tap", h_tap[a+21], 7);
        chk("read_rv", h_rv[a+2], 1);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) step();
            cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31),
                $urandom_range(0, 3));
        end

        cmd(1, 0, 12, 0);
        step();
        d = cyc;
        rdy = 1'b0;
        busy_rise = d + 1;
        step();
        step();
        step();
        rc = cyc;
        raise_rdy();
        wait_idle();
        step();
        chk("rdydrop_busy", h_busy[d+1], 1);
        chk("reinit_ld1", h_ld[rc + 1 + (1+S)], 5'b00010);
        chk("reinit_cv1", h_cv[rc + 1 + (1+S)], 12);

        start_cmd(4, 0, 20);
        step();
        step();
        r = cyc;
        do_reset();
        step();
        step();
        chk("rst_ld", h_ld[r+1] | h_ld[r+2] | h_ld[r+3], 0);
        chk("rst_ce", h_ce[r+1] | h_ce[r+2] | h_ce[r+3], 0);
        chk("rst_busy", h_busy[r+3], 1);
        chk("rst_rsp_valid", h_rv[r+3], 0);
        raise_rdy();
        wait_idle();
        cmd(4, 3, 0, 0);
        a = acc;
        chk("post_rst_read", h_tap[a+2], 7);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgmii_idelay_ctrl.md
RGMII_IDELAY_CTRL -- requirements
Module: rgmii_idelay_ctrl

Interface
REQ-001 Parameter LANES, default 5: number of IDELAYE2 lanes in VAR_LOAD mode (rxd[3:0], rx_ctl).
REQ-002 Parameter DEFAULT_TAP, default 0: 5-bit tap loaded into every lane at init.
REQ-003 Parameter SETTLE_CYCLES, default 4: wait cycles between an ld/ce pulse and readback, range 1..15.
REQ-004 clk  input  1  system clock; the same clock drives the IDELAYE2 C pins.
REQ-005 rst  input  1  reset, synchronous to clk, active-high.
REQ-006 idelayctrl_rdy  input  1  IDELAYCTRL RDY, already synchronized to clk.
REQ-007 cmd_valid  input  1 / cmd_ready  output  1  command handshake.
REQ-008 cmd_lane  input  3  target lane / cmd_op  input  2  00 load, 01 inc, 10 dec, 11 read / cmd_tap  input  5  tap value for load.
REQ-009 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-010 rsp_tap  output  5  CNTVALUEOUT readback / rsp_err  output  1  command rejected or readback mismatch.
REQ-011 idelay_ld  output  LANES  per-lane LD strobe / idelay_ce  output  LANES  per-lane CE strobe.
REQ-012 idelay_inc  output  1  shared INC / idelay_cntvaluein  output  5  shared CNTVALUEIN.
REQ-013 idelay_cntvalueout  input  LANES*5  per-lane CNTVALUEOUT; lane n occupies bits [5n+4:5n].
REQ-014 busy  output  1  high until the init load of all lanes has completed.

Function
REQ-015 FSM states: WAIT_RDY, INIT_LD, INIT_SETTLE, IDLE, APPLY, SETTLE, VERIFY, RESP.
REQ-016 Per-lane shadow register holds the last tap that was loaded or stepped; each shadow resets to DEFAULT_TAP.
REQ-017 WAIT_RDY: stays until idelayctrl_rdy=1, then goes to INIT_LD with lane index 0.
REQ-018 INIT_LD: pulses idelay_ld[i] for 1 cycle with cntvaluein=shadow[i], then goes to INIT_SETTLE for SETTLE_CYCLES cycles, then to the next lane; after lane LANES-1 goes to IDLE and drops busy.
REQ-019 cmd_ready is 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready (cycle 0) and its fields are captured.
REQ-020 Load: in cycle 1 (APPLY), idelay_ld[lane]=1 and cntvaluein=cmd_tap; shadow[lane]<=cmd_tap.
REQ-021 Inc/dec: in cycle 1, idelay_ce[lane]=1 and idelay_inc=(op==01); shadow steps by ±1.
REQ-022 Saturation: inc with shadow=31 or dec with shadow=0 produces no ce pulse, leaves shadow unchanged and sets rsp_err=1.
REQ-023 Read: no ld/ce pulse; SETTLE is skipped.
REQ-024 Invalid lane (cmd_lane>=LANES): no pulse, rsp_tap=0, rsp_err=1, response in cycle 1.
REQ-025 SETTLE lasts SETTLE_CYCLES cycles; VERIFY samples cntvalueout[lane] into rsp_tap; rsp_err=1 if rsp_tap!=shadow[lane] (or saturation).
REQ-026 Valid load/inc/dec: rsp_valid is asserted in cycle 2+SETTLE_CYCLES; valid read: rsp_valid is asserted in cycle 2.
REQ-027 RESP: rsp_valid, rsp_tap and rsp_err hold stable until rsp_ready=1; the cycle after the handshake the FSM is in IDLE (earliest next accept).
REQ-028 At most one ld or ce bit is high in any cycle; idelay_ld and idelay_ce are never high together.
REQ-029 idelayctrl_rdy falling in IDLE: go to WAIT_RDY, assert busy, and re-run init from the shadows (not from DEFAULT_TAP).
REQ-030 idelayctrl_rdy falling during APPLY..RESP: finish the current command including its response, then go to WAIT_RDY.
REQ-031 idelayctrl_rdy falling during INIT: return to WAIT_RDY and restart at lane 0.

Reset
REQ-032 On rst: state=WAIT_RDY, busy=1, cmd_ready=0, rsp_valid=0, rsp_tap=0, rsp_err=0, ld=0, ce=0, inc=0, cntvaluein=0, shadows=DEFAULT_TAP.
REQ-033 rst asserted mid-command or mid-init aborts immediately with no further pulses; a pending response is discarded.

Structure
REQ-034 Op encodings, TAP_W=5 and the FSM state encoding live in a shared package, rgmii_idelay_pkg.
REQ-035 Single flat module with no sub-modules; the settle counter and lane index are local counters.

Verification
REQ-036 Reset, rdy=1 at cycle 10, DEFAULT_TAP=7 -> five single-cycle ld pulses (lanes 0..4), each with cntvaluein=7 and spaced 1+SETTLE_CYCLES apart; then busy=0.
REQ-037 Load lane 2 tap 19, model echoes 19 -> ld[2] in cycle 1; rsp_valid in cycle 6 with rsp_tap=19, rsp_err=0.
REQ-038 Load lane 0 tap 31, then inc lane 0 -> no ce pulse, rsp_err=1, rsp_tap=31; dec from 31 -> ce[0]=1, inc=0, rsp_tap=30.
REQ-039 cmd_lane=6 -> no pulses, rsp_valid in cycle 1 with rsp_err=1 and rsp_tap=0; model returns 5 after a load of 9 -> rsp_err=1.
REQ-040 rsp_ready held low for 20 cycles -> rsp_valid and rsp_tap stable and cmd_ready=0 throughout.
REQ-041 After loading lane 1 with 12, drop rdy in IDLE, then restore it -> busy=1 and re-init reloads lane 1 with 12; rst during SETTLE -> all strobes 0 and state WAIT_RDY.
